// File: rtl/acia_uart_if.sv
// acia_uart_if: CPU-side bus of the ACIA.
//   cs   chip select (CPU address in ACIA page)
//   we   write enable, qualified by cs
//   rs   register select: 0 status/control, 1 data
//   din  CPU write data
//   dout registered read data (valid one clk after the access)
//   irq  level interrupt request, active-high
// master = CPU side, slave = ACIA side.
interface acia_uart_if;
    logic       cs;
    logic       we;
    logic       rs;
    logic [7:0] din;
    logic [7:0] dout;
    logic       irq;

    modport master (output cs, output we, output rs, output din, input dout, input irq);
    modport slave  (input cs, input we, input rs, input din, output dout, output irq);
endinterface

// File: rtl/acia_uart.sv
// acia_uart: memory-mapped 8N1 UART for the 6502 SoC.
//   clk  system clock, rising edge
//   rst  asynchronous reset, active-high
//   rx   serial receive line, asynchronous, idle high
//   tx   serial transmit line, idle high
//   bus  CPU bus (acia_uart_if.slave): cs/we/rs/din in, dout/irq out
// Register map: rs=0 read status {irq,4'b0,ferr,overrun,tx_empty,rx_full},
// rs=0 write ctrl {.., tx_irq_en, rx_irq_en}, rs=1 read rx_hold / write starts TX.
module acia_uart #(
    parameter int unsigned BAUD_DIV = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    acia_uart_if.slave bus
);
    localparam int unsigned CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] CntLast = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] CntHalf = CW'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    // Bus decode
    logic data_wr, ctrl_wr, data_rd, stat_rd, rd;
    assign rd      = bus.cs & ~bus.we;
    assign data_wr = bus.cs & bus.we & bus.rs;
    assign ctrl_wr = bus.cs & bus.we & ~bus.rs;
    assign data_rd = rd & bus.rs;
    assign stat_rd = rd & ~bus.rs;

    // TX state
    state_e        tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_q, tx_d;
    logic          tx_empty;

    // RX state
    logic          rx_meta_q, rx_sync_q, rx_prev_q;
    state_e        rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_done;

    // Registers and flags
    logic [7:0] rx_hold_q, rx_hold_d;
    logic       rx_full_q, rx_full_d;
    logic       overrun_q, overrun_d;
    logic       ferr_q, ferr_d;
    logic [1:0] ctrl_q, ctrl_d;
    logic       irq_q, irq_d;
    logic [7:0] dout_q, dout_d;
    logic [7:0] status;

    assign tx_empty = (tx_state_q == StIdle);
    assign status   = {irq_q, 4'b0000, ferr_q, overrun_q, tx_empty, rx_full_q};
    assign tx       = tx_q;
    assign bus.dout = dout_q;
    assign bus.irq  = irq_q;

    // TX FSM next state; tx is registered so the line changes on the state edge
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        unique case (tx_state_q)
            StIdle: begin
                if (data_wr) begin
                    tx_state_d = StStart;
                    tx_shift_d = bus.din;
                    tx_cnt_d   = '0;
                    tx_d       = 1'b0;
                end
            end
            StStart: begin
                if (tx_cnt_q == CntLast) begin
                    tx_state_d = StData;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_d       = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            StData: begin
                if (tx_cnt_q == CntLast) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = StStop;
                        tx_d       = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_d       = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            StStop: begin
                if (tx_cnt_q == CntLast) begin
                    tx_state_d = StIdle;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            default: begin
                tx_state_d = StIdle;
                tx_d       = 1'b1;
            end
        endcase
    end

    // RX FSM next state; start is validated at mid-bit to reject glitches
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_done    = 1'b0;
        unique case (rx_state_q)
            StIdle: begin
                if (rx_prev_q & ~rx_sync_q) begin
                    rx_state_d = StStart;
                    rx_cnt_d   = '0;
                end
            end
            StStart: begin
                if (rx_cnt_q == CntHalf) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    rx_state_d = rx_sync_q ? StIdle : StData;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            StData: begin
                if (rx_cnt_q == CntLast) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = StStop;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            StStop: begin
                if (rx_cnt_q == CntLast) begin
                    rx_done    = 1'b1;
                    rx_state_d = StIdle;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            default: rx_state_d = StIdle;
        endcase
    end

    // Flags, control, read data and irq. Sets from a completing frame win over
    // same-edge read clears; a data read on the completion edge frees the holding
    // register so the new byte is accepted without overrun.
    always_comb begin
        rx_hold_d = rx_hold_q;
        rx_full_d = data_rd ? 1'b0 : rx_full_q;
        overrun_d = stat_rd ? 1'b0 : overrun_q;
        ferr_d    = stat_rd ? 1'b0 : ferr_q;
        ctrl_d    = ctrl_wr ? bus.din[1:0] : ctrl_q;
        if (rx_done) begin
            if (!rx_sync_q) ferr_d = 1'b1;
            if (rx_full_q && !data_rd) begin
                overrun_d = 1'b1;
            end else begin
                rx_hold_d = rx_shift_q;
                rx_full_d = 1'b1;
            end
        end
        dout_d = rd ? (bus.rs ? rx_hold_q : status) : dout_q;
        irq_d  = (ctrl_q[0] & rx_full_q) | (ctrl_q[1] & tx_empty);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= StIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= StIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_hold_q  <= '0;
            rx_full_q  <= 1'b0;
            overrun_q  <= 1'b0;
            ferr_q     <= 1'b0;
            ctrl_q     <= '0;
            irq_q      <= 1'b0;
            dout_q     <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_hold_q  <= rx_hold_d;
            rx_full_q  <= rx_full_d;
            overrun_q  <= overrun_d;
            ferr_q     <= ferr_d;
            ctrl_q     <= ctrl_d;
            irq_q      <= irq_d;
            dout_q     <= dout_d;
        end
    end
endmodule

// File: tb/tb_acia_uart.sv
// tb_acia_uart: self-checking bench for acia_uart with BAUD_DIV=8.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_acia_uart;
    localparam int unsigned BAUD = 8;

    logic clk = 1'b0;
    logic rst;
    logic rx;
    logic tx;

    acia_uart_if bus ();

    acia_uart #(.BAUD_DIV(BAUD)) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx),
        .tx  (tx),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model of the register file (TX assumed idle when status is read)
    logic [7:0] m_hold;
    bit         m_full, m_ovr, m_ferr;
    logic [1:0] m_ctrl;

    function automatic void model_reset();
        m_hold = 8'h00; m_full = 0; m_ovr = 0; m_ferr = 0; m_ctrl = 2'b00;
    endfunction

    function automatic void model_frame(input logic [7:0] b, input logic stop);
        if (!stop) m_ferr = 1;
        if (m_full) m_ovr = 1;
        else begin
            m_hold = b;
            m_full = 1;
        end
    endfunction

    function automatic logic [7:0] model_status_read();
        logic irq;
        logic [7:0] s;
        irq = (m_ctrl[0] & m_full) | m_ctrl[1];
        s = {irq, 4'b0000, m_ferr, m_ovr, 1'b1, m_full};
        m_ovr = 0;
        m_ferr = 0;
        return s;
    endfunction

    function automatic logic [7:0] model_data_read();
        m_full = 0;
        return m_hold;
    endfunction

    task automatic bus_write(input logic r, input logic [7:0] d);
        @(negedge clk);
        bus.cs = 1'b1; bus.we = 1'b1; bus.rs = r; bus.din = d;
        @(negedge clk);
        bus.cs = 1'b0; bus.we = 1'b0;
        if (!r) m_ctrl = d[1:0];
    endtask

    task automatic bus_read(input logic r, output logic [7:0] d);
        @(negedge clk);
        bus.cs = 1'b1; bus.we = 1'b0; bus.rs = r;
        @(negedge clk);
        d = bus.dout;
        bus.cs = 1'b0;
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (BAUD) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(negedge clk);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        model_frame(b, stop);
    endtask

    // Launch one TX frame and check every bit time, tx_empty at the end, and
    // optionally that a write in mid-frame is ignored.
    task automatic tx_frame(input logic [7:0] data, input bit extra_write);
        logic exp;
        bus_write(1'b1, data);
        for (int i = 0; i < 82; i++) begin
            if (i < 8) exp = 1'b0;
            else if (i < 72) exp = data[(i - 8) / 8];
            else exp = 1'b1;
            checks++;
            if (tx !== exp) begin
                errors++;
                $display("FAIL tx_bit[%0d] data=%h got %b want %b", i, data, tx, exp);
            end
            if (i == 20 && extra_write) begin
                bus.cs = 1'b1; bus.we = 1'b1; bus.rs = 1'b1; bus.din = ~data;
            end
            if (i == 21) begin
                bus.cs = 1'b0; bus.we = 1'b0;
            end
            if (i == 78 || i == 80) begin
                bus.cs = 1'b1; bus.we = 1'b0; bus.rs = 1'b0;
            end
            if (i == 79 || i == 81) begin
                checks++;
                if (bus.dout[1] !== (i == 81)) begin
                    errors++;
                    $display("FAIL tx_empty[%0d] got %b want %b", i, bus.dout[1], (i == 81));
                end
                bus.cs = 1'b0;
                m_ovr = 0;
                m_ferr = 0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [7:0] v;
        checks++;
        if (tx !== 1'b1 || bus.dout !== 8'h00 || bus.irq !== 1'b0) begin
            errors++;
            $display("FAIL por_outputs got tx=%b dout=%h irq=%b want 1 00 0", tx, bus.dout, bus.irq);
        end
        @(negedge clk); rst = 1'b0;
        bus_read(1'b0, v);
        checks++;
        if (v !== model_status_read()) begin
            errors++;
            $display("FAIL por_status got %h want 02", v);
        end
        // Reset in the middle of a frame with both irq enables set
        bus_write(1'b0, 8'h03);
        bus_write(1'b1, 8'hC3);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (tx !== 1'b1 || bus.irq !== 1'b0) begin
            errors++;
            $display("FAIL rst_async got tx=%b irq=%b want 1 0", tx, bus.irq);
        end
        @(negedge clk); rst = 1'b0;
        model_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (tx !== 1'b1 || bus.irq !== 1'b0 || bus.dout !== 8'h00) begin
                errors++;
                $display("FAIL rst_after[%0d] got tx=%b irq=%b dout=%h want 1 0 00", i, tx,
                         bus.irq, bus.dout);
            end
        end
        bus_read(1'b0, v);
        checks++;
        if (v !== 8'h02) begin
            errors++;
            $display("FAIL rst_status got %h want 02", v);
        end
    endtask

    task automatic test_tx();
        tx_frame(8'h55, 1'b1);
    endtask

    task automatic test_rx();
        logic [7:0] v, e;
        send_frame(8'hA5, 1'b1);
        bus_read(1'b0, v);
        e = model_status_read();
        checks++;
        if (v !== e) begin errors++; $display("FAIL rx_status_full got %h want %h", v, e); end
        bus_read(1'b1, v);
        e = model_data_read();
        checks++;
        if (v !== e) begin errors++; $display("FAIL rx_data got %h want %h", v, e); end
        bus_read(1'b0, v);
        e = model_status_read();
        checks++;
        if (v !== e) begin errors++; $display("FAIL rx_status_after got %h want %h", v, e); end
    endtask

    task automatic test_overrun_ferr();
        logic [7:0] v, e;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        bus_read(1'b1, v);
        e = model_data_read();
        checks++;
        if (v !== e) begin errors++; $display("FAIL ovr_data got %h want %h", v, e); end
        send_frame(8'h33, 1'b0);
        bus_read(1'b0, v);
        e = model_status_read();
        checks++;
        if (v !== e) begin errors++; $display("FAIL ovr_ferr_status got %h want %h", v, e); end
        bus_read(1'b1, v);
        e = model_data_read();
        checks++;
        if (v !== e) begin errors++; $display("FAIL ferr_data got %h want %h", v, e); end
        bus_read(1'b0, v);
        e = model_status_read();
        checks++;
        if (v !== e) begin errors++; $display("FAIL flags_cleared got %h want %h", v, e); end
    endtask

    task automatic test_irq();
        logic [7:0] v, e;
        bit seen;
        logic prev;
        bus_write(1'b0, 8'h01);
        @(negedge clk);
        checks++;
        if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_idle_rxen got %b want 0", bus.irq); end
        seen = 0;
        bus.cs = 1'b1; bus.we = 1'b0; bus.rs = 1'b0;
        fork
            send_frame(8'h3C, 1'b1);
            begin
                prev = bus.irq;
                for (int k = 0; k < 120; k++) begin
                    @(negedge clk);
                    if (bus.dout[0] === 1'b1) begin
                        seen = 1;
                        checks++;
                        if (bus.irq !== 1'b1 || prev !== 1'b0) begin
                            errors++;
                            $display("FAIL irq_rx_rise got irq=%b prev=%b want 1 0", bus.irq, prev);
                        end
                        break;
                    end
                    prev = bus.irq;
                end
            end
        join
        bus.cs = 1'b0;
        checks++;
        if (!seen) begin errors++; $display("FAIL irq_rx_timeout got rx_full=0 want 1"); end
        bus_read(1'b1, v);
        e = model_data_read();
        checks++;
        if (v !== e) begin errors++; $display("FAIL irq_data got %h want %h", v, e); end
        @(negedge clk);
        checks++;
        if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_drop got %b want 0", bus.irq); end
        bus_write(1'b0, 8'h02);
        @(negedge clk);
        checks++;
        if (bus.irq !== 1'b1) begin errors++; $display("FAIL irq_tx_idle got %b want 1", bus.irq); end
        bus_write(1'b1, 8'h0F);
        @(negedge clk);
        checks++;
        if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_tx_busy got %b want 0", bus.irq); end
        repeat (82) @(negedge clk);
        checks++;
        if (bus.irq !== 1'b1) begin errors++; $display("FAIL irq_tx_done got %b want 1", bus.irq); end
        bus_write(1'b0, 8'h00);
        @(negedge clk);
        checks++;
        if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_off got %b want 0", bus.irq); end
    endtask

    task automatic test_glitch();
        logic [7:0] v, e, b;
        @(negedge clk); rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        bus_read(1'b0, v);
        e = model_status_read();
        checks++;
        if (v !== e) begin errors++; $display("FAIL glitch_status got %h want %h", v, e); end
        b = 8'($urandom);
        send_frame(b, 1'b1);
        bus_read(1'b1, v);
        e = model_data_read();
        checks++;
        if (v !== e) begin errors++; $display("FAIL glitch_recover got %h want %h", v, e); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] v, e, b;
        for (int n = 0; n < 4; n++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1);
            bus_read(1'b1, v);
            e = model_data_read();
            checks++;
            if (v !== e) begin errors++; $display("FAIL b2b_data[%0d] got %h want %h", n, v, e); end
            bus_read(1'b0, v);
            e = model_status_read();
            checks++;
            if (v !== e) begin errors++; $display("FAIL b2b_status[%0d] got %h want %h", n, v, e); end
        end
        for (int n = 0; n < 2; n++) begin
            b = 8'($urandom);
            tx_frame(b, n[0]);
        end
    endtask

    initial begin
        rst = 1'b1;
        rx = 1'b1;
        bus.cs = 1'b0; bus.we = 1'b0; bus.rs = 1'b0; bus.din = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        test_tx();
        test_rx();
        test_overrun_ferr();
        test_irq();
        test_glitch();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
